// File: rtl/store_align_unit_if.sv
// Store request / data-memory write bundle for store_align_unit.
// The unit uses the slave modport; the requester/memory side uses master.
interface store_align_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [1:0]        req_size;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_we;
    logic              done;
    logic              size_err;
    logic              misalign_fault;

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_we,
               done, size_err, misalign_fault
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_we,
               done, size_err, misalign_fault
    );
endinterface

// File: rtl/store_align_unit.sv
// Store aligner: byte-lane shifts store data, builds byte enables and splits word-crossing stores.
// Optional macro STORE_MISALIGN_TRAP_EN: boundary-crossing stores retire with misalign_fault instead of splitting.
module store_align_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    store_align_unit_if.slave   sif
);

`ifdef STORE_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [3:0] base_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b1111;
            2'b01:   m = 4'b0011;
            2'b10:   m = 4'b0001;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] keep_bytes(input logic [DATA_W-1:0] data,
                                                     input logic [3:0]        bm);
        return data & {{8{bm[3]}}, {8{bm[2]}}, {8{bm[1]}}, {8{bm[0]}}};
    endfunction

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   hi_addr_r, hi_addr_s;
    logic [DATA_W-1:0]   hi_data_r, hi_data_s;
    logic [3:0]          hi_mask_r, hi_mask_s;
    logic                req_ready_r, req_ready_s;
    logic                mem_valid_r, mem_valid_s;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_s;
    logic [3:0]          mem_we_r, mem_we_s;
    logic                done_r, done_s;
    logic                size_err_r, size_err_s;
    logic                fault_r, fault_s;

    logic [1:0]          off_s;
    logic [3:0]          bm_s;
    logic [7:0]          m8_s;
    logic [2*DATA_W-1:0] d64_s;
    logic [ADDR_W-1:0]   word_addr_s;
    logic                cross_s;

    // Lane arithmetic on the incoming request, used only at the accept edge
    always_comb begin
        off_s       = sif.req_addr[1:0];
        bm_s        = base_mask(sif.req_size);
        m8_s        = {4'b0000, bm_s} << off_s;
        d64_s       = {{DATA_W{1'b0}}, keep_bytes(sif.req_data, bm_s)} << {off_s, 3'b000};
        word_addr_s = {sif.req_addr[ADDR_W-1:2], 2'b00};
        cross_s     = (m8_s[7:4] != 4'b0000);
    end

    // Next-state and next-output logic; every output is registered from these values
    always_comb begin
        state_s     = state_r;
        hi_addr_s   = hi_addr_r;
        hi_data_s   = hi_data_r;
        hi_mask_s   = hi_mask_r;
        req_ready_s = req_ready_r;
        mem_valid_s = mem_valid_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        mem_we_s    = mem_we_r;
        done_s      = 1'b0;
        size_err_s  = 1'b0;
        fault_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sif.req_valid && req_ready_r) begin
                    req_ready_s = 1'b0;
                    hi_addr_s   = word_addr_s + ADDR_W'(32'd4);
                    hi_data_s   = d64_s[2*DATA_W-1:DATA_W];
                    hi_mask_s   = m8_s[7:4];
                    if (sif.req_size == 2'b11) begin
                        state_s    = ST_DONE;
                        done_s     = 1'b1;
                        size_err_s = 1'b1;
                    end else if (TRAP_EN && cross_s) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                        fault_s = 1'b1;
                    end else begin
                        state_s     = ST_BEAT0;
                        mem_valid_s = 1'b1;
                        mem_addr_s  = word_addr_s;
                        mem_wdata_s = d64_s[DATA_W-1:0];
                        mem_we_s    = m8_s[3:0];
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BEAT0: begin
                if (sif.mem_ready) begin
                    if (hi_mask_r != 4'b0000) begin
                        state_s     = ST_BEAT1;
                        mem_addr_s  = hi_addr_r;
                        mem_wdata_s = hi_data_r;
                        mem_we_s    = hi_mask_r;
                    end else begin
                        state_s     = ST_DONE;
                        mem_valid_s = 1'b0;
                        mem_addr_s  = {ADDR_W{1'b0}};
                        mem_wdata_s = {DATA_W{1'b0}};
                        mem_we_s    = 4'b0000;
                        done_s      = 1'b1;
                    end
                end else begin
                    state_s = ST_BEAT0;
                end
            end
            ST_BEAT1: begin
                if (sif.mem_ready) begin
                    state_s     = ST_DONE;
                    mem_valid_s = 1'b0;
                    mem_addr_s  = {ADDR_W{1'b0}};
                    mem_wdata_s = {DATA_W{1'b0}};
                    mem_we_s    = 4'b0000;
                    done_s      = 1'b1;
                end else begin
                    state_s = ST_BEAT1;
                end
            end
            ST_DONE: begin
                state_s     = ST_IDLE;
                req_ready_s = 1'b1;
            end
            default: begin
                state_s     = ST_IDLE;
                req_ready_s = 1'b1;
                mem_valid_s = 1'b0;
                mem_addr_s  = {ADDR_W{1'b0}};
                mem_wdata_s = {DATA_W{1'b0}};
                mem_we_s    = 4'b0000;
            end
        endcase
    end

    // State and output registers; reset abandons any request in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            hi_addr_r   <= {ADDR_W{1'b0}};
            hi_data_r   <= {DATA_W{1'b0}};
            hi_mask_r   <= 4'b0000;
            req_ready_r <= 1'b1;
            mem_valid_r <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            mem_we_r    <= 4'b0000;
            done_r      <= 1'b0;
            size_err_r  <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            hi_addr_r   <= hi_addr_s;
            hi_data_r   <= hi_data_s;
            hi_mask_r   <= hi_mask_s;
            req_ready_r <= req_ready_s;
            mem_valid_r <= mem_valid_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            mem_we_r    <= mem_we_s;
            done_r      <= done_s;
            size_err_r  <= size_err_s;
            fault_r     <= fault_s;
        end
    end

    assign sif.req_ready      = req_ready_r;
    assign sif.mem_valid      = mem_valid_r;
    assign sif.mem_addr       = mem_addr_r;
    assign sif.mem_wdata      = mem_wdata_r;
    assign sif.mem_we         = mem_we_r;
    assign sif.done           = done_r;
    assign sif.size_err       = size_err_r;
    assign sif.misalign_fault = fault_r;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed, table-driven bench for store_align_unit plus stall and mid-operation reset sequences.
module tb_store_align_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    store_align_unit_if #(.ADDR_W(32), .DATA_W(32)) sif ();

    store_align_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        int          nb;
        logic [31:0] a0;
        logic [31:0] w0;
        logic [3:0]  e0;
        logic [31:0] a1;
        logic [31:0] w1;
        logic [3:0]  e1;
        logic        serr;
        logic        fault;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   bi;
        bit   seen_done;
        v = vecs[idx];
        bi = 0;
        seen_done = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_ready_idle", idx), {31'd0, sif.req_ready}, 32'd1);
        sif.req_size  = v.size;
        sif.req_addr  = v.addr;
        sif.req_data  = v.data;
        sif.req_valid = 1'b1;
        @(posedge clk);
        #1 sif.req_valid = 1'b0;
        for (int c = 1; c <= 12 && !seen_done; c++) begin
            @(negedge clk);
            if (sif.mem_valid) begin
                checks++;
                if (bi >= v.nb) begin
                    errors++;
                    $display("FAIL v%0d_extra_beat: got beat %0d expected %0d beats", idx, bi, v.nb);
                end else begin
                    chk($sformatf("v%0d_b%0d_addr", idx, bi), sif.mem_addr, (bi == 0) ? v.a0 : v.a1);
                    chk($sformatf("v%0d_b%0d_wdata", idx, bi), sif.mem_wdata, (bi == 0) ? v.w0 : v.w1);
                    chk($sformatf("v%0d_b%0d_we", idx, bi), {28'd0, sif.mem_we}, {28'd0, (bi == 0) ? v.e0 : v.e1});
                end
                bi++;
            end
            if (sif.done) begin
                seen_done = 1'b1;
                chk($sformatf("v%0d_beats", idx), bi, v.nb);
                chk($sformatf("v%0d_latency", idx), c, v.nb + 1);
                chk($sformatf("v%0d_size_err", idx), {31'd0, sif.size_err}, {31'd0, v.serr});
                chk($sformatf("v%0d_fault", idx), {31'd0, sif.misalign_fault}, {31'd0, v.fault});
            end else begin
                chk($sformatf("v%0d_busy_ready", idx), {31'd0, sif.req_ready}, 32'd0);
            end
        end
        if (!seen_done) begin
            checks++;
            errors++;
            $display("FAIL v%0d_timeout: got no done expected done within 12 cycles", idx);
        end
        @(negedge clk);
        chk($sformatf("v%0d_done_pulse", idx), {31'd0, sif.done}, 32'd0);
        chk($sformatf("v%0d_ready_back", idx), {31'd0, sif.req_ready}, 32'd1);
    endtask

    initial begin
        int          pre;
        logic [31:0] stall_addr;
        bit          got_done;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        sif.req_valid = 1'b0;
        sif.req_addr  = 32'd0;
        sif.req_data  = 32'd0;
        sif.req_size  = 2'b00;
        sif.mem_ready = 1'b1;

        vecs[0] = '{2'b10, 32'h0000_0103, 32'h1234_56AB, 1, 32'h0000_0100, 32'hAB00_0000, 4'b1000, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0};
        vecs[1] = '{2'b01, 32'h0000_0102, 32'hFFFF_1234, 1, 32'h0000_0100, 32'h1234_0000, 4'b1100, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0};
`ifdef STORE_MISALIGN_TRAP_EN
        vecs[2] = '{2'b00, 32'h0000_0201, 32'hDEAD_BEEF, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b1};
        vecs[3] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_BEEF, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b1};
        vecs[8] = '{2'b01, 32'h0000_0103, 32'h0000_5678, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b1};
`else
        vecs[2] = '{2'b00, 32'h0000_0201, 32'hDEAD_BEEF, 2, 32'h0000_0200, 32'hADBE_EF00, 4'b1110, 32'h0000_0204, 32'h0000_00DE, 4'b0001, 1'b0, 1'b0};
        vecs[3] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_BEEF, 2, 32'hFFFF_FFFC, 32'hEF00_0000, 4'b1000, 32'h0000_0000, 32'h0000_00BE, 4'b0001, 1'b0, 1'b0};
        vecs[8] = '{2'b01, 32'h0000_0103, 32'h0000_5678, 2, 32'h0000_0100, 32'h7800_0000, 4'b1000, 32'h0000_0104, 32'h0000_0056, 4'b0001, 1'b0, 1'b0};
`endif
        vecs[4] = '{2'b11, 32'h0000_0300, 32'h5555_5555, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b0};
        vecs[5] = '{2'b00, 32'h0000_0040, 32'hCAFE_F00D, 1, 32'h0000_0040, 32'hCAFE_F00D, 4'b1111, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0};
        vecs[6] = '{2'b10, 32'h0000_0000, 32'hFFFF_FF5A, 1, 32'h0000_0000, 32'h0000_005A, 4'b0001, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0};
        vecs[7] = '{2'b01, 32'h0000_0101, 32'hAAAA_1234, 1, 32'h0000_0100, 32'h0012_3400, 4'b0110, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0};
        vecs[9] = '{2'b10, 32'h0000_1002, 32'h0000_0077, 1, 32'h0000_1000, 32'h0077_0000, 4'b0100, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0};

        // Reset state
        @(negedge clk);
        chk("rst_req_ready", {31'd0, sif.req_ready}, 32'd1);
        chk("rst_mem_valid", {31'd0, sif.mem_valid}, 32'd0);
        chk("rst_done", {31'd0, sif.done}, 32'd0);
        chk("rst_mem_we", {28'd0, sif.mem_we}, 32'd0);
        chk("rst_mem_addr", sif.mem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(i);

        // Back-pressure: memory stalls an aligned word store for three cycles
        @(negedge clk);
        sif.mem_ready = 1'b0;
        sif.req_size  = 2'b00;
        sif.req_addr  = 32'h0000_0040;
        sif.req_data  = 32'h1357_9BDF;
        sif.req_valid = 1'b1;
        @(posedge clk);
        #1 sif.req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("hold_c%0d_valid", c), {31'd0, sif.mem_valid}, 32'd1);
            chk($sformatf("hold_c%0d_addr", c), sif.mem_addr, 32'h0000_0040);
            chk($sformatf("hold_c%0d_wdata", c), sif.mem_wdata, 32'h1357_9BDF);
            chk($sformatf("hold_c%0d_we", c), {28'd0, sif.mem_we}, 32'h0000_000F);
            chk($sformatf("hold_c%0d_ready", c), {31'd0, sif.req_ready}, 32'd0);
        end
        sif.mem_ready = 1'b1;
        @(negedge clk);
        chk("hold_done", {31'd0, sif.done}, 32'd1);
        chk("hold_valid_drop", {31'd0, sif.mem_valid}, 32'd0);
        @(negedge clk);
        chk("hold_ready_back", {31'd0, sif.req_ready}, 32'd1);

        // Reset while a beat is stalled: mem_valid must drop without waiting for a clock
`ifdef STORE_MISALIGN_TRAP_EN
        pre = 0;
        stall_addr = 32'h0000_0040;
        sif.req_addr = 32'h0000_0040;
`else
        pre = 1;
        stall_addr = 32'h0000_0204;
        sif.req_addr = 32'h0000_0201;
`endif
        @(negedge clk);
        sif.req_size  = 2'b00;
        sif.req_data  = 32'hDEAD_BEEF;
        sif.req_valid = 1'b1;
        @(posedge clk);
        #1 sif.req_valid = 1'b0;
        for (int c = 0; c < pre; c++) begin
            @(negedge clk);
            chk("rstseq_pre_valid", {31'd0, sif.mem_valid}, 32'd1);
        end
        @(negedge clk);
        sif.mem_ready = 1'b0;
        chk("rstseq_stall_valid", {31'd0, sif.mem_valid}, 32'd1);
        chk("rstseq_stall_addr", sif.mem_addr, stall_addr);
        #2 rst_n = 1'b0;
        #1;
        chk("rstseq_async_valid", {31'd0, sif.mem_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstseq_ready_after", {31'd0, sif.req_ready}, 32'd1);
        sif.mem_ready = 1'b1;
        got_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rstseq_no_beat_c%0d", c), {31'd0, sif.mem_valid}, 32'd0);
            if (sif.done) got_done = 1'b1;
        end
        chk("rstseq_no_done", {31'd0, got_done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
